// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the seven-segment scan driver
//
// Purpose: sub-tick count per digit slot, the hex-to-segment table with its
// lookup function, and a width helper for the prescaler counter.
// Ports: none (package).

package seg7_pkg;

  // Each digit slot is split into this many PWM sub-ticks; sub-tick 0 is dead time.
  localparam int SUBTICKS = 16;

  // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by hex nibble.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

  // clog2(TICK_DIV), but never narrower than one bit so TICK_DIV=1 still
  // yields a legal (always-zero) prescaler register.
  function automatic int presc_width(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to seven-segment decoder
//
// Purpose: maps one hex nibble to its active-high segment pattern.
// Ports:
//   nib  in  4  hex digit
//   seg  out 7  segments {g,f,e,d,c,b,a}

module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver with PWM and double buffering
//
// Purpose: scans DIGITS hex digits onto shared segment lines, double-buffers
// loaded values so a frame never mixes old and new data, applies 4-bit PWM
// brightness with a dead sub-tick per slot, and optional leading-zero blanking.
// Ports:
//   clocksource  in  1          system clock (rising edge)
//   reset        in  1          asynchronous active-high reset
//   value        in  4*DIGITS   hex nibbles, nibble 0 = digit 0 (least significant)
//   dp           in  DIGITS     decimal-point request per digit
//   load         in  1          strobe capturing value/dp into the pending buffer
//   bright       in  4          brightness 0..15, sampled every cycle
//   lzs          in  1          leading-zero suppression enable
//   seg          out 7          segments {g,f,e,d,c,b,a}, active-high
//   dp_out       out 1          decimal-point segment, active-high
//   an           out DIGITS     digit anodes, active-low
//   frame_start  out 1          one-cycle pulse at each frame boundary

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 64
) (
  input  logic                  clocksource,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic [3:0]            bright,
  input  logic                  lzs,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int PW = presc_width(TICK_DIV);
  localparam int DW = $clog2(DIGITS);

  logic [PW-1:0]       presc;
  logic [3:0]          subtick;
  logic [DW-1:0]       digit;

  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic [4*DIGITS-1:0] shad_val;
  logic [DIGITS-1:0]   shad_dp;

  logic                presc_wrap;
  logic                sub_wrap;
  logic                digit_last;
  logic                boundary;

  logic [3:0]          nibs [DIGITS];
  logic [3:0]          cur_nib;
  logic [6:0]          dec_seg;
  logic [DIGITS-1:0]   blank_vec;
  logic                zero_above;
  logic                active;
  logic [DIGITS-1:0]   an_next;

  assign presc_wrap = (presc == PW'(TICK_DIV - 1));
  assign sub_wrap   = (subtick == 4'(SUBTICKS - 1));
  assign digit_last = (digit == DW'(DIGITS - 1));
  assign boundary   = (presc == '0) && (subtick == 4'd0) && (digit == '0);

  // Prescaler -> sub-tick -> digit index ripple counter.
  always_ff @(posedge clocksource or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      subtick <= '0;
      digit   <= '0;
    end else begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap) begin
        subtick <= subtick + 1'b1;
        if (sub_wrap) begin
          digit <= digit_last ? '0 : digit + 1'b1;
        end
      end
    end
  end

  // Pending/shadow buffers. A load landing on the boundary bypasses pending
  // so the new value shows in the frame that starts right now.
  always_ff @(posedge clocksource or posedge reset) begin
    if (reset) begin
      pend_val <= '0;
      pend_dp  <= '0;
      shad_val <= '0;
      shad_dp  <= '0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp;
      end
      if (boundary) begin
        shad_val <= load ? value : pend_val;
        shad_dp  <= load ? dp    : pend_dp;
      end
    end
  end

  // Blanking: walk from the most significant digit down; a digit is blank
  // while it and everything above it are zero. Digit 0 is never blank.
  always_comb begin
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nibs[i] = shad_val[4*i +: 4];
    end
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (nibs[i] == 4'h0);
      blank_vec[i] = lzs & zero_above;
    end
  end

  assign cur_nib = nibs[digit];

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  // Sub-tick 0 is always dark, so the digit change never shows as ghosting.
  assign active = (subtick != 4'd0) && (subtick <= bright) && !blank_vec[digit];

  always_comb begin
    an_next = '1;
    if (active) begin
      an_next[digit] = 1'b0;
    end
  end

  always_ff @(posedge clocksource or posedge reset) begin
    if (reset) begin
      seg         <= 7'h00;
      dp_out      <= 1'b0;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= active ? dec_seg : 7'h00;
      dp_out      <= active ? shad_dp[digit] : 1'b0;
      an          <= an_next;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (DIGITS=4, TICK_DIV=2)

module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic [3:0]  bright;
  logic        lzs;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_start;

  seg7_scan_driver #(.DIGITS(4), .TICK_DIV(2)) dut (
    .clocksource (clk),
    .reset       (reset),
    .value       (value),
    .dp          (dp),
    .load        (load),
    .bright      (bright),
    .lzs         (lzs),
    .seg         (seg),
    .dp_out      (dp_out),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] SEGS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_checks = 0;
  int n_err    = 0;
  int on_cnt   = 0;

  // Reference model: k = clock edges since reset release.
  int          k = 0;
  logic [15:0] m_pend_v = '0;
  logic [3:0]  m_pend_dp = '0;
  logic [15:0] m_shad_v = '0;
  logic [3:0]  m_shad_dp = '0;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Expected {seg, dp_out, an, frame_start} after the edge taken at time k.
  function automatic logic [12:0] model_out();
    int         sub;
    int         d;
    logic [3:0] nib;
    logic       blank;
    logic       act;
    logic [3:0] an_e;
    sub   = (k / 2) % 16;
    d     = (k / 32) % 4;
    nib   = m_shad_v[4*d +: 4];
    blank = lzs && (d > 0) && ((m_shad_v >> (4*d)) == 16'h0);
    act   = (sub >= 1) && (sub <= int'(bright)) && !blank;
    an_e  = 4'hF;
    if (act) an_e[d] = 1'b0;
    return {act ? SEGS[nib] : 7'h00, act ? m_shad_dp[d] : 1'b0, an_e, (k % 128) == 0};
  endfunction

  task automatic tick(input string tag);
    logic [12:0] e;
    e = model_out();
    if ((k % 128) == 0) begin
      m_shad_v  = load ? value : m_pend_v;
      m_shad_dp = load ? dp    : m_pend_dp;
    end
    if (load) begin
      m_pend_v  = value;
      m_pend_dp = dp;
    end
    k++;
    @(posedge clk);
    #1;
    check(tag, {seg, dp_out, an, frame_start}, e);
    if (an !== 4'hF) on_cnt++;
  endtask

  task automatic align(input string tag);
    while ((k % 128) != 0) tick(tag);
  endtask

  task automatic run_frame(input string tag, input int exp_on);
    on_cnt = 0;
    repeat (128) tick(tag);
    check({tag, "_oncount"}, 13'(on_cnt), 13'(exp_on));
  endtask

  task automatic load_now(input logic [15:0] v, input logic [3:0] d, input string tag);
    value = v;
    dp    = d;
    load  = 1'b1;
    tick(tag);
    load  = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    value  = '0;
    dp     = '0;
    load   = 1'b0;
    bright = 4'd15;
    lzs    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {seg, dp_out, an, frame_start}, {7'h00, 1'b0, 4'hF, 1'b0});
    reset = 1'b0;

    // Idle after reset: digit 0 shows 3F everywhere, 4 digits * 30 on-clocks.
    run_frame("idle", 120);

    // Mid-frame load: old content stays until the next boundary.
    repeat (40) tick("pre_load");
    load_now(16'h12AF, 4'b0100, "load_mid");
    align("load_mid_wait");
    run_frame("show_12af", 120);

    bright = 4'd4;
    run_frame("bright4", 32);
    bright = 4'd0;
    run_frame("bright0", 0);

    bright = 4'd15;
    lzs    = 1'b1;
    load_now(16'h0040, 4'b1111, "lzs_load");
    align("lzs_wait");
    run_frame("lzs_0040", 60);
    load_now(16'h0000, 4'b1111, "lzs_load0");
    align("lzs0_wait");
    run_frame("lzs_0000", 30);

    // Load exactly on the boundary cycle: same frame must already show 8888.
    lzs = 1'b0;
    load_now(16'h8888, 4'b0000, "bnd_load");
    repeat (127) tick("bnd_frame");
    run_frame("bnd_next", 120);

    // Random loads, brightness and suppression changes.
    repeat (768) begin
      if ($urandom_range(0, 59) == 0) bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 79) == 0) lzs = ~lzs;
      if ($urandom_range(0, 39) == 0) begin
        value = 16'($urandom);
        if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
        dp    = 4'($urandom);
        load  = 1'b1;
      end
      tick("random");
      load = 1'b0;
    end

    // Asynchronous reset while digit 2 is lit.
    bright = 4'd15;
    lzs    = 1'b0;
    load_now(16'h12AF, 4'b0100, "rst_load");
    align("rst_wait");
    repeat (74) tick("rst_pre");
    check("digit2_lit", {seg, dp_out, an, frame_start}, {7'h5B, 1'b1, 4'b1011, 1'b0});
    reset = 1'b1;
    #2;
    check("async_reset", {seg, dp_out, an, frame_start}, {7'h00, 1'b0, 4'hF, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    k         = 0;
    m_pend_v  = '0;
    m_pend_dp = '0;
    m_shad_v  = '0;
    m_shad_dp = '0;
    run_frame("after_reset", 120);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multiplexed seven-segment scan driver for DIGITS hex digits, with per-digit decimal points.
- Adds double-buffered loading, so a frame never shows mixed values.
- Adds 4-bit PWM brightness with a dead-time sub-tick for anti-ghosting, plus optional leading-zero suppression.
- Sits between the datapath that produces the values and the board's segment/anode pins.

Parameters:
- DIGITS, 4, number of multiplexed digits; legal range 2..8.
- TICK_DIV, 64, clocks per PWM sub-tick; must be ≥1. Each digit slot lasts 16 sub-ticks.

Ports:
- clocksource  in  1  system clock; everything runs on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is least significant.
- dp  in  DIGITS  decimal-point request per digit.
- load  in  1  one-cycle strobe that captures value and dp into the pending buffer.
- bright  in  4  brightness level, 0 (dark) to 15. Sampled every cycle; no buffering.
- lzs  in  1  leading-zero suppression enable. Sampled every cycle.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dp_out  out  1  decimal-point segment, active-high.
- an  out  DIGITS  digit anodes, active-low.
- frame_start  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - seg = 7'h00, dp_out = 0, an = all ones, frame_start = 0.
  - Prescaler, sub-tick counter and digit index = 0.
  - Pending and shadow buffers = 0.
- Counters:
  - The prescaler counts 0..TICK_DIV-1; its wrap advances the sub-tick counter, 0..15.
  - The sub-tick wrap advances the digit index 0..DIGITS-1, which wraps back to 0.
  - Slot = 16*TICK_DIV clocks; frame = DIGITS slots.
- Frame boundary: the cycle in which the counters are at (digit 0, sub-tick 0, prescaler 0). This includes the first cycle after reset is released.
- Buffering:
  - load=1 copies value and dp into pending.
  - At the frame boundary, shadow <= pending.
  - If load and the frame boundary coincide, shadow takes value/dp directly in that cycle, and pending takes them too.
  - Display always uses shadow.
- Digit enable, for current digit i: active = (1 ≤ subtick ≤ bright) AND NOT blank(i).
  - Sub-tick 0 is always dead time.
  - bright=0 gives a permanently dark display; bright=15 gives 15/16 duty.
- Blanking:
  - blank(i) = lzs AND shadow nibble i == 0 AND every nibble j>i == 0, for i>0.
  - Digit 0 is never blanked.
  - A blanked digit also suppresses its dp.
- Outputs are registered, one clock behind the counter state:
  - an: the bit for the current digit is low when active; all other bits are high.
  - seg: the hex decode of shadow nibble i when active, otherwise 7'h00.
  - dp_out: shadow dp[i] when active, otherwise 0.
- Hex decode, hex values:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- frame_start is high for exactly the one registered cycle that corresponds to the frame boundary.
- At most one anode is ever low. No glitch is allowed between slots: the digit change always falls in dead sub-tick 0.
- Reset asserted mid-frame blanks the outputs immediately. The scan restarts at digit 0 after release, and any pending data is lost.
- Changing bright or lzs mid-slot takes effect on the next sub-tick evaluation.

Decomposition:
- Package seg7_pkg holds:
  - SUBTICKS = 16.
  - The 16-entry segment constant table and a hex_to_seg function.
  - A localparam helper for the prescaler width, clog2(TICK_DIV).
- One combinational sub-module, seg7_hex_decode: 4-bit in, 7-bit out, built on the package table.
- Counters, buffers, blanking and output registers stay in the top module.

Test Plan (DIGITS=4, TICK_DIV=2: slot = 32 clocks, frame = 128 clocks):
- Reset, then release with no load → seg=00, dp_out=0, an=4'b1111 during every sub-tick 0. During active sub-ticks with bright=15, digit 0 shows seg=3F with an=4'b1110. frame_start pulses every 128 clocks.
- load value=16'h12AF, dp=4'b0100, bright=15, mid-frame → the old value is displayed until the next frame_start. Afterwards:
  - digit0 seg=71, digit1 seg=77, digit2 seg=5B with dp_out=1, digit3 seg=06.
  - Each digit is on for 30 of its 32 clocks.
- bright=4 → per slot, an is low for exactly 8 clocks, sub-ticks 1..4. bright=0 → an stays 4'b1111 for a whole frame.
- lzs=1, value=16'h0040 → digits 3 and 2 stay dark (an bit high, dp suppressed), digit1 seg=66, digit0 seg=3F. With value=16'h0000, only digit 0 lights, showing 3F.
- load asserted in the frame-boundary cycle with value=16'h8888 → the new value is displayed in that same frame (seg=7F on all digits).
- Assert reset mid-slot while digit 2 is lit → an=4'b1111 and seg=00 asynchronously, before the next clock edge. After release, scanning restarts at digit 0 and shadow = 0.
